// File: rtl/mem_arb_pkg.sv
// Shared types for the two-client memory arbiter: client ids and arbiter states.
package mem_arb_pkg;

    typedef logic client_id_t;

    localparam client_id_t ICACHE_ID = 1'b0;
    localparam client_id_t DCACHE_ID = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arb_order_fifo.sv
// Order FIFO recording which client owns each in-flight memory request.
module mem_arb_order_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_in,
    input  logic [WIDTH-1:0]         push_data_in,
    input  logic                     pop_in,
    output logic [WIDTH-1:0]         head_out,
    output logic                     full_out,
    output logic                     empty_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full_out  = (r_count == FULL_CNT);
    assign empty_out = (r_count == '0);
    assign count_out = r_count;
    assign head_out  = r_mem[r_rd_ptr];
    assign w_push    = push_in & ~full_out;
    assign w_pop     = pop_in & ~empty_out;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_in;
        end
    end

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) memory arbiter with in-order response routing.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise dcache has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BUS_WIDTH       = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [1:0]                         req_valid_in,
    input  logic [2*ADDR_WIDTH-1:0]            req_addr_in,
    input  logic [2*BUS_WIDTH-1:0]             req_data_in,
    input  logic [1:0]                         req_we_in,
    output logic [1:0]                         req_ready_out,
    output logic [1:0]                         resp_valid_out,
    output logic [BUS_WIDTH-1:0]               resp_data_out,
    input  logic [1:0]                         resp_ready_in,
    output logic                               mem_req_valid_out,
    output logic [ADDR_WIDTH-1:0]              mem_req_addr_out,
    output logic [BUS_WIDTH-1:0]               mem_req_data_out,
    output logic                               mem_req_we_out,
    input  logic                               mem_req_ready_in,
    input  logic                               mem_resp_valid_in,
    input  logic [BUS_WIDTH-1:0]               mem_resp_data_in,
    output logic                               mem_resp_ready_out,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_out,
    output logic                               err_out
);

    arb_state_t            r_state;
    client_id_t            r_winner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BUS_WIDTH-1:0]  r_data;
    logic                  r_we;
    logic                  r_err;
`ifdef MEM_ARB_RR_EN
    client_id_t            r_rr_ptr;
`endif

    logic [ADDR_WIDTH-1:0] w_cli_addr [2];
    logic [BUS_WIDTH-1:0]  w_cli_data [2];
    client_id_t            w_pick;
    client_id_t            w_winner;
    client_id_t            w_head;
    logic                  w_locked;
    logic                  w_grant;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_abandon;

    assign w_cli_addr[0] = req_addr_in[ADDR_WIDTH-1:0];
    assign w_cli_addr[1] = req_addr_in[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign w_cli_data[0] = req_data_in[BUS_WIDTH-1:0];
    assign w_cli_data[1] = req_data_in[2*BUS_WIDTH-1:BUS_WIDTH];

    always_comb begin
        w_pick = ICACHE_ID;
`ifdef MEM_ARB_RR_EN
        if (req_valid_in == 2'b11) begin
            w_pick = r_rr_ptr;
        end else if (req_valid_in[DCACHE_ID]) begin
            w_pick = DCACHE_ID;
        end
`else
        if (req_valid_in[DCACHE_ID]) begin
            w_pick = DCACHE_ID;
        end
`endif
    end

    // A full FIFO blocks new grants regardless of a same-cycle pop.
    assign w_locked  = (r_state == LOCKED);
    assign w_grant   = ~reset & (w_locked | ((|req_valid_in) & ~w_full));
    assign w_winner  = w_locked ? r_winner : w_pick;
    assign w_accept  = w_grant & mem_req_ready_in;
    assign w_abandon = w_locked & ~req_valid_in[r_winner];

    assign mem_req_valid_out = w_grant;
    assign mem_req_addr_out  = w_locked ? r_addr : w_cli_addr[w_winner];
    assign mem_req_data_out  = w_locked ? r_data : w_cli_data[w_winner];
    assign mem_req_we_out    = w_locked ? r_we   : req_we_in[w_winner];

    always_comb begin
        req_ready_out = 2'b00;
        if (w_accept) begin
            req_ready_out[w_winner] = 1'b1;
        end
    end

    // With nothing outstanding, a stray response is consumed and discarded.
    always_comb begin
        resp_valid_out     = 2'b00;
        mem_resp_ready_out = 1'b0;
        if (!w_empty) begin
            resp_valid_out[w_head] = mem_resp_valid_in;
            mem_resp_ready_out     = resp_ready_in[w_head];
        end else begin
            mem_resp_ready_out = mem_resp_valid_in;
        end
    end

    assign resp_data_out = mem_resp_data_in;
    assign w_pop         = mem_resp_valid_in & mem_resp_ready_out & ~w_empty;
    assign w_drop        = mem_resp_valid_in & w_empty;
    assign err_out       = r_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_winner <= ICACHE_ID;
            r_err    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_rr_ptr <= DCACHE_ID;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant && !mem_req_ready_in) begin
                        r_state  <= LOCKED;
                        r_winner <= w_pick;
                    end
                end
                LOCKED: begin
                    if (mem_req_ready_in) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_drop || w_abandon) begin
                r_err <= 1'b1;
            end
`ifdef MEM_ARB_RR_EN
            if (w_accept) begin
                r_rr_ptr <= ~w_winner;
            end
`endif
        end
    end

    // Captured on entry to LOCKED so the memory sees a stable request.
    always_ff @(posedge clock) begin
        if (!w_locked) begin
            r_addr <= w_cli_addr[w_pick];
            r_data <= w_cli_data[w_pick];
            r_we   <= req_we_in[w_pick];
        end
    end

    mem_arb_order_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_order_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_in      (w_accept),
        .push_data_in (w_winner),
        .pop_in       (w_pop),
        .head_out     (w_head),
        .full_out     (w_full),
        .empty_out    (w_empty),
        .count_out    (outstanding_out)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter; checks against a queue-based owner model.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  v = '0;
    logic [1:0]  we = '0;
    logic [1:0]  rrdy = '0;
    logic [31:0] a [2];
    logic [63:0] d [2];
    logic        mrdy = 1'b0;
    logic        mrv = 1'b0;
    logic [63:0] mrd = '0;

    logic [1:0]  w_req_ready;
    logic [1:0]  w_resp_valid;
    logic [63:0] w_resp_data;
    logic        w_mvalid;
    logic [31:0] w_maddr;
    logic [63:0] w_mdata;
    logic        w_mwe;
    logic        w_mrr;
    logic [2:0]  w_out;
    logic        w_err;

    int passes = 0;
    int total  = 0;
    int own_q [$];
    logic [63:0] mdat_q [$];

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock              (clock),
        .reset              (reset),
        .req_valid_in       (v),
        .req_addr_in        ({a[1], a[0]}),
        .req_data_in        ({d[1], d[0]}),
        .req_we_in          (we),
        .req_ready_out      (w_req_ready),
        .resp_valid_out     (w_resp_valid),
        .resp_data_out      (w_resp_data),
        .resp_ready_in      (rrdy),
        .mem_req_valid_out  (w_mvalid),
        .mem_req_addr_out   (w_maddr),
        .mem_req_data_out   (w_mdata),
        .mem_req_we_out     (w_mwe),
        .mem_req_ready_in   (mrdy),
        .mem_resp_valid_in  (mrv),
        .mem_resp_data_in   (mrd),
        .mem_resp_ready_out (w_mrr),
        .outstanding_out    (w_out),
        .err_out            (w_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    // Returns every outstanding response and checks it reaches its recorded owner.
    task automatic drain_all;
        while (own_q.size() > 0) begin
            tick;
            mrv  = 1'b1;
            rrdy = 2'b11;
            mrd  = {$urandom, $urandom};
            settle;
            chk("drain_owner", w_resp_valid, 2'b01 << own_q[0]);
            chk("drain_data", w_resp_data, mrd);
            chk("drain_ready", w_mrr, 1'b1);
            void'(own_q.pop_front());
        end
        tick;
        mrv  = 1'b0;
        rrdy = 2'b00;
        settle;
        chk("drain_empty", w_out, 0);
    endtask

    initial begin
        int win;
        int held;
        int last;
        int h;
        logic [1:0] pend;

        a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
        tick;
        tick;
        reset = 1'b0;
        settle;
        chk("rst_out", w_out, 0);
        chk("rst_err", w_err, 0);
        chk("rst_mvalid", w_mvalid, 0);
        chk("rst_rready", w_req_ready, 0);
        chk("rst_rvalid", w_resp_valid, 0);
        chk("rst_mrr", w_mrr, 0);

        // Single icache load, response three cycles later.
        tick;
        v = 2'b01; a[0] = 32'h1000; we = 2'b00; mrdy = 1'b1;
        settle;
        chk("ld_mvalid", w_mvalid, 1);
        chk("ld_addr", w_maddr, 32'h1000);
        chk("ld_rready", w_req_ready, 2'b01);
        chk("ld_we", w_mwe, 0);
        tick;
        v = 2'b00; mrdy = 1'b0;
        settle;
        chk("ld_out1", w_out, 1);
        tick;
        tick;
        mrv = 1'b1; mrd = 64'hDEAD; rrdy = 2'b01;
        settle;
        chk("ld_rvalid", w_resp_valid, 2'b01);
        chk("ld_rdata", w_resp_data, 64'hDEAD);
        chk("ld_mrr", w_mrr, 1);
        tick;
        mrv = 1'b0; rrdy = 2'b00;
        settle;
        chk("ld_out0", w_out, 0);

        // Four contested cycles.
        for (int i = 0; i < 4; i++) begin
            tick;
            v = 2'b11; a[0] = 32'h2000 + i; a[1] = 32'h3000 + i; mrdy = 1'b1;
            settle;
            win = (RR_MODE && (i % 2 == 1)) ? 0 : 1;
            chk("arb_rready", w_req_ready, 2'b01 << win);
            chk("arb_addr", w_maddr, a[win]);
            own_q.push_back(win);
        end
        tick;
        v = 2'b00; mrdy = 1'b0;
        settle;
        chk("arb_out4", w_out, 4);
        drain_all;

        // Memory stalls for five cycles with dcache locked in.
        tick;
        v = 2'b10; a[1] = 32'hD000; d[1] = 64'h5555; we = 2'b10; mrdy = 1'b0;
        settle;
        chk("lk_mvalid", w_mvalid, 1);
        chk("lk_addr0", w_maddr, 32'hD000);
        chk("lk_rready0", w_req_ready, 0);
        for (int i = 1; i < 5; i++) begin
            tick;
            if (i == 2) begin
                v = 2'b11; a[0] = 32'hA000; d[0] = 64'h7777; we = 2'b10;
            end
            settle;
            chk("lk_addr", w_maddr, 32'hD000);
            chk("lk_data", w_mdata, 64'h5555);
            chk("lk_we", w_mwe, 1);
            chk("lk_mvalid_hold", w_mvalid, 1);
            chk("lk_rready", w_req_ready, 0);
        end
        tick;
        mrdy = 1'b1;
        settle;
        chk("lk_accept", w_req_ready, 2'b10);
        chk("lk_addr_acc", w_maddr, 32'hD000);
        own_q.push_back(1);
        tick;
        v = 2'b01;
        settle;
        chk("lk_icache", w_req_ready, 2'b01);
        chk("lk_iaddr", w_maddr, 32'hA000);
        own_q.push_back(0);
        tick;
        v = 2'b00; mrdy = 1'b0; we = 2'b00;
        drain_all;

        // Fill to capacity, then check the no-bypass rule and push/pop balance.
        for (int i = 0; i < 4; i++) begin
            tick;
            win = (i == 1 || i == 2) ? 1 : 0;
            v = 2'b01 << win; a[win] = 32'hC000 + i; mrdy = 1'b1;
            settle;
            chk("fill_rready", w_req_ready, 2'b01 << win);
            own_q.push_back(win);
        end
        tick;
        v = 2'b00;
        settle;
        chk("fill_out4", w_out, 4);
        tick;
        v = 2'b01; a[0] = 32'hB000; mrv = 1'b1; rrdy = 2'b11;
        settle;
        chk("full_mvalid", w_mvalid, 0);
        chk("full_rready", w_req_ready, 0);
        chk("full_rvalid", w_resp_valid, 2'b01 << own_q[0]);
        void'(own_q.pop_front());
        tick;
        settle;
        chk("pp_out3", w_out, 3);
        chk("pp_rready", w_req_ready, 2'b01);
        chk("pp_rvalid", w_resp_valid, 2'b01 << own_q[0]);
        void'(own_q.pop_front());
        own_q.push_back(0);
        tick;
        v = 2'b00; mrv = 1'b0; mrdy = 1'b0;
        settle;
        chk("pp_out_same", w_out, 3);
        drain_all;

        // Stray response with nothing outstanding.
        tick;
        mrv = 1'b1; rrdy = 2'b00;
        settle;
        chk("stray_mrr", w_mrr, 1);
        chk("stray_rvalid", w_resp_valid, 0);
        chk("stray_err_pre", w_err, 0);
        tick;
        mrv = 1'b0;
        settle;
        chk("stray_err", w_err, 1);
        tick;
        tick;
        settle;
        chk("stray_sticky", w_err, 1);

        // Reset with two requests outstanding.
        tick;
        v = 2'b01; mrdy = 1'b1;
        tick;
        v = 2'b10;
        tick;
        v = 2'b00; mrdy = 1'b0;
        settle;
        chk("mid_out2", w_out, 2);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        settle;
        chk("mid_out0", w_out, 0);
        chk("mid_err0", w_err, 0);
        tick;
        mrv = 1'b1;
        settle;
        chk("post_rvalid", w_resp_valid, 0);
        chk("post_mrr", w_mrr, 1);
        tick;
        mrv = 1'b0;
        settle;
        chk("post_err", w_err, 1);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;

        // Client abandons a locked request.
        v = 2'b01; a[0] = 32'hE000; mrdy = 1'b0;
        settle;
        chk("ab_mvalid", w_mvalid, 1);
        tick;
        v = 2'b00;
        settle;
        chk("ab_hold", w_mvalid, 1);
        chk("ab_err0", w_err, 0);
        tick;
        settle;
        chk("ab_err1", w_err, 1);
        chk("ab_addr", w_maddr, 32'hE000);
        mrdy = 1'b1;
        settle;
        chk("ab_accept", w_req_ready, 2'b01);
        own_q.push_back(0);
        tick;
        mrdy = 1'b0;
        drain_all;

        // Randomized traffic against the owner-queue model.
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        own_q.delete();
        mdat_q.delete();
        held = -1;
        last = 0;
        pend = 2'b00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick;
            for (int c = 0; c < 2; c++) begin
                if (!pend[c] && ($urandom_range(0, 2) == 0)) begin
                    pend[c] = 1'b1;
                    a[c]    = $urandom;
                    d[c]    = {$urandom, $urandom};
                    we[c]   = 1'($urandom_range(0, 1));
                end
            end
            v    = pend;
            mrdy = ($urandom_range(0, 3) != 0);
            rrdy = 2'($urandom_range(0, 3));
            mrv  = (own_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mrd  = mrv ? mdat_q[0] : {$urandom, $urandom};
            settle;
            win = -1;
            if (held >= 0) begin
                win = held;
            end else if (own_q.size() < 4 && pend != 2'b00) begin
                if (pend == 2'b11) win = RR_MODE ? 1 - last : 1;
                else win = pend[1] ? 1 : 0;
            end
            chk("rnd_mvalid", w_mvalid, win >= 0);
            if (win >= 0) begin
                chk("rnd_addr", w_maddr, a[win]);
                chk("rnd_data", w_mdata, d[win]);
                chk("rnd_we", w_mwe, we[win]);
            end
            chk("rnd_rready", w_req_ready, (win >= 0 && mrdy) ? (2'b01 << win) : 2'b00);
            h = -1;
            if (own_q.size() > 0) begin
                h = own_q[0];
                chk("rnd_rvalid", w_resp_valid, mrv ? (2'b01 << h) : 2'b00);
                chk("rnd_mrr", w_mrr, rrdy[h]);
                if (mrv) chk("rnd_rdata", w_resp_data, mrd);
            end else begin
                chk("rnd_rvalid_e", w_resp_valid, 0);
                chk("rnd_mrr_e", w_mrr, 0);
            end
            chk("rnd_out", w_out, own_q.size());
            chk("rnd_err", w_err, 0);
            if (h >= 0 && mrv && rrdy[h]) begin
                void'(own_q.pop_front());
                void'(mdat_q.pop_front());
            end
            if (win >= 0) begin
                if (mrdy) begin
                    own_q.push_back(win);
                    mdat_q.push_back({$urandom, $urandom});
                    pend[win] = 1'b0;
                    held = -1;
                    last = win;
                end else begin
                    held = win;
                end
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
